muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer for the RV32 core that adds MUL/DIV/DIVU/REM/REMU without a dedicated multiplier or divider. It borrows the shared `execute` ALU for a fixed number of cycles, issuing OP_ADD/OP_SUB/OP_SLTU micro-operations and keeping its own shift registers. It sits beside `execute` in the EX stage. The core's operand mux hands the ALU to this block while `alu_busy_o` is high.

---
 rtl/yarp_pkg.sv | 54 +++++
 rtl/muldiv_seq.sv | 198 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/yarp_pkg.sv
// Shared definitions for the yarp core: ALU function codes plus the
// operation and state encodings used by the iterative multiply/divide sequencer.
package yarp_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SLL  = 4'h2;
  localparam logic [3:0] OP_SRL  = 4'h3;
  localparam logic [3:0] OP_SRA  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_SLTU = 4'h8;
  localparam logic [3:0] OP_SLT  = 4'h9;

  typedef enum logic [2:0] {
    MD_MUL  = 3'd0,
    MD_DIV  = 3'd1,
    MD_DIVU = 3'd2,
    MD_REM  = 3'd3,
    MD_REMU = 3'd4
  } muldiv_op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_NEG_A   = 3'd1,
    ST_NEG_B   = 3'd2,
    ST_MUL_IT  = 3'd3,
    ST_DIV_CMP = 3'd4,
    ST_DIV_SUB = 3'd5,
    ST_FIX     = 3'd6,
    ST_DONE    = 3'd7
  } muldiv_state_t;

  // Both loops run 32 steps; the counter value of the final step.
  localparam logic [4:0] MD_LAST_ITER = 5'd31;

  // Unused opcode values 5-7 fall back to a plain multiply.
  function automatic muldiv_op_t decode_muldiv_op(input logic [2:0] code);
    case (code)
      3'd1:    return MD_DIV;
      3'd2:    return MD_DIVU;
      3'd3:    return MD_REM;
      3'd4:    return MD_REMU;
      default: return MD_MUL;
    endcase
  endfunction

  // Signed divide/remainder work on magnitudes and correct the sign at the end.
  function automatic logic is_signed_div(input muldiv_op_t op);
    return (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative MUL/DIV/DIVU/REM/REMU sequencer. It owns no adder of its own:
// every arithmetic step is issued as a micro-op to the shared execute ALU,
// whose combinational result comes back on alu_res_i in the same cycle.
module muldiv_seq
  import yarp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  input  logic [2:0]  req_op_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  output logic        req_ready_o,
  input  logic        flush_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_res_o,
  output logic        alu_busy_o,
  output logic [31:0] alu_opr_a_o,
  output logic [31:0] alu_opr_b_o,
  output logic [3:0]  alu_funct_o,
  input  logic [31:0] alu_res_i
);

  muldiv_state_t state;
  muldiv_state_t state_next;

  // opa holds the multiplicand (shifting left) or the dividend/quotient;
  // opb holds the multiplier (shifting right) or the divisor.
  muldiv_op_t  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] acc;
  logic [31:0] rem;
  logic [31:0] rem_shift;
  logic [4:0]  iter;
  logic        neg_q;
  logic        neg_r;
  logic        top;
  logic        lt;

  logic        accept;
  logic        last_iter;
  logic        qbit;
  logic [31:0] rem_cand;
  logic [31:0] fix_sel;
  logic        fix_neg;

  // A flush arriving together with a request cancels the acceptance.
  assign accept    = (state == ST_IDLE) && req_valid_i && !flush_i;
  assign last_iter = (iter == MD_LAST_ITER);
  assign rem_cand  = {rem[30:0], opa[31]};
  assign qbit      = top | ~lt;

  // Pick the value to finish with and whether its sign must be flipped.
  always_comb begin
    fix_sel = acc;
    fix_neg = 1'b0;
    case (op)
      MD_DIV: begin
        fix_sel = opa;
        fix_neg = neg_q;
      end
      MD_DIVU: fix_sel = opa;
      MD_REM: begin
        fix_sel = rem;
        fix_neg = neg_r;
      end
      MD_REMU: fix_sel = rem;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic plus the ALU micro-op issued in each state.
  always_comb begin
    state_next   = state;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    alu_busy_o   = 1'b1;
    alu_opr_a_o  = 32'd0;
    alu_opr_b_o  = 32'd0;
    alu_funct_o  = OP_ADD;
    case (state)
      ST_IDLE: begin
        alu_busy_o  = 1'b0;
        req_ready_o = 1'b1;
        if (accept) state_next = ST_NEG_A;
      end
      ST_NEG_A: begin
        alu_funct_o = OP_SUB;
        alu_opr_b_o = opa;
        state_next  = ST_NEG_B;
      end
      ST_NEG_B: begin
        alu_funct_o = OP_SUB;
        alu_opr_b_o = opb;
        state_next  = (op == MD_MUL) ? ST_MUL_IT : ST_DIV_CMP;
      end
      ST_MUL_IT: begin
        alu_funct_o = OP_ADD;
        alu_opr_a_o = acc;
        alu_opr_b_o = opa;
        if (last_iter) state_next = ST_FIX;
      end
      ST_DIV_CMP: begin
        alu_funct_o = OP_SLTU;
        alu_opr_a_o = rem_cand;
        alu_opr_b_o = opb;
        state_next  = ST_DIV_SUB;
      end
      ST_DIV_SUB: begin
        alu_funct_o = OP_SUB;
        alu_opr_a_o = rem_shift;
        alu_opr_b_o = opb;
        state_next  = last_iter ? ST_FIX : ST_DIV_CMP;
      end
      ST_FIX: begin
        alu_funct_o = OP_SUB;
        alu_opr_b_o = fix_sel;
        state_next  = ST_DONE;
      end
      ST_DONE: begin
        resp_valid_o = 1'b1;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (flush_i && (state != ST_IDLE)) begin
      state_next   = ST_IDLE;
      resp_valid_o = 1'b0;
    end
  end

  // Datapath registers: operand capture, sign handling, shift-add and restoring divide steps.
  always_ff @(posedge clk) begin
    if (reset) begin
      op         <= MD_MUL;
      opa        <= 32'd0;
      opb        <= 32'd0;
      acc        <= 32'd0;
      rem        <= 32'd0;
      rem_shift  <= 32'd0;
      iter       <= 5'd0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      top        <= 1'b0;
      lt         <= 1'b0;
      resp_res_o <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op   <= decode_muldiv_op(req_op_i);
            opa  <= req_a_i;
            opb  <= req_b_i;
            acc  <= 32'd0;
            rem  <= 32'd0;
            iter <= 5'd0;
          end
        end
        ST_NEG_A: begin
          if (is_signed_div(op) && opa[31]) opa <= alu_res_i;
          neg_q <= (opa[31] ^ opb[31]) & (opb != 32'd0);
          neg_r <= opa[31];
        end
        ST_NEG_B: begin
          if (is_signed_div(op) && opb[31]) opb <= alu_res_i;
        end
        ST_MUL_IT: begin
          if (opb[0]) acc <= alu_res_i;
          opa  <= {opa[30:0], 1'b0};
          opb  <= {1'b0, opb[31:1]};
          iter <= iter + 5'd1;
        end
        ST_DIV_CMP: begin
          rem_shift <= rem_cand;
          top       <= rem[31];
          lt        <= alu_res_i[0];
        end
        ST_DIV_SUB: begin
          rem  <= qbit ? alu_res_i : rem_shift;
          opa  <= {opa[30:0], qbit};
          iter <= iter + 5'd1;
        end
        ST_FIX: begin
          if (!flush_i) resp_res_o <= fix_neg ? alu_res_i : fix_sel;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: models the shared ALU, drives directed
// and random requests, and compares result, latency and handshake behaviour
// against a plain-arithmetic reference.
`timescale 1ns/1ps
module tb_muldiv_seq;
  import yarp_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic        flush;
  logic        resp_valid;
  logic [31:0] resp_res;
  logic        alu_busy;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_funct;
  logic [31:0] alu_res;

  int nTests = 0;
  int nFail  = 0;

  muldiv_seq dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid),
    .req_op_i     (req_op),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_ready_o  (req_ready),
    .flush_i      (flush),
    .resp_valid_o (resp_valid),
    .resp_res_o   (resp_res),
    .alu_busy_o   (alu_busy),
    .alu_opr_a_o  (alu_a),
    .alu_opr_b_o  (alu_b),
    .alu_funct_o  (alu_funct),
    .alu_res_i    (alu_res)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared execute ALU.
  always_comb begin
    case (alu_funct)
      OP_ADD:  alu_res = alu_a + alu_b;
      OP_SUB:  alu_res = alu_a - alu_b;
      OP_SLTU: alu_res = {31'd0, alu_a < alu_b};
      default: alu_res = 32'd0;
    endcase
  end

  // Guard against a hung simulation.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] refModel(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (code)
      3'd1: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return sa / sb;
      end
      3'd2: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      3'd3: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return sa % sb;
      end
      3'd4: return (b == 32'd0) ? a : a % b;
      default: return a * b;
    endcase
  endfunction

  task automatic checkIdleAlu(input string tag);
    checkOutput({tag, " alu_a"}, alu_a, 32'd0);
    checkOutput({tag, " alu_b"}, alu_b, 32'd0);
    checkOutput({tag, " alu_funct"}, {28'd0, alu_funct}, {28'd0, OP_ADD});
  endtask

  // Issue one request and follow it to its response.
  task automatic applyStimulus(input string tag, input logic [2:0] code, input logic [31:0] a,
                               input logic [31:0] b, input bit holdValid);
    int obs;
    int seenAt;
    int expLat;
    logic ownOk;
    logic [31:0] expRes;
    expRes = refModel(code, a, b);
    expLat = (code >= 3'd1 && code <= 3'd4) ? 68 : 36;
    @(negedge clk);
    checkOutput({tag, " ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = code;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    if (!holdValid) req_valid = 1'b0;
    obs    = 1;
    seenAt = 0;
    ownOk  = 1'b1;
    while (seenAt == 0 && obs <= 100) begin
      if (req_ready || !alu_busy) ownOk = 1'b0;
      if (resp_valid) seenAt = obs;
      else begin
        @(posedge clk);
        #1;
        obs++;
      end
    end
    req_valid = 1'b0;
    checkOutput({tag, " own"}, {31'd0, ownOk}, 32'd1);
    checkOutput({tag, " latency"}, seenAt, expLat);
    checkOutput({tag, " result"}, resp_res, expRes);
    @(posedge clk);
    #1;
    checkOutput({tag, " after"}, {29'd0, req_ready, alu_busy, resp_valid}, 32'b100);
    checkOutput({tag, " held"}, resp_res, expRes);
  endtask

  initial begin
    logic sawResp;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rc;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = 32'd0;
    req_b     = 32'd0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset ready", {31'd0, req_ready}, 32'd1);
    checkOutput("reset valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("reset res", resp_res, 32'd0);
    checkOutput("reset busy", {31'd0, alu_busy}, 32'd0);
    checkIdleAlu("reset");
    @(negedge clk);
    reset = 1'b0;

    applyStimulus("mul 7x6", 3'd0, 32'd7, 32'd6, 1'b0);
    checkIdleAlu("idle");
    applyStimulus("mul -1x-1", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    applyStimulus("div -7/2", 3'd1, 32'hFFFFFFF9, 32'd2, 1'b0);
    applyStimulus("rem -7/2", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
    applyStimulus("divu", 3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    applyStimulus("div 5/0", 3'd1, 32'd5, 32'd0, 1'b0);
    applyStimulus("div -5/0", 3'd1, 32'hFFFFFFFB, 32'd0, 1'b0);
    applyStimulus("remu x/0", 3'd4, 32'h1234, 32'd0, 1'b0);
    applyStimulus("div ovf", 3'd1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    applyStimulus("rem ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    applyStimulus("op7 mul", 3'd7, 32'd12345, 32'd678, 1'b0);

    // Flush in the middle of a divide.
    sawResp = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd1;
    req_a     = 32'd100;
    req_b     = 32'd7;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int k = 1; k < 10; k++) begin
      if (resp_valid) sawResp = 1'b1;
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    if (resp_valid) sawResp = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush ready", {31'd0, req_ready}, 32'd1);
    checkOutput("flush busy", {31'd0, alu_busy}, 32'd0);
    for (int k = 0; k < 70; k++) begin
      if (resp_valid) sawResp = 1'b1;
      @(posedge clk);
      #1;
    end
    checkOutput("flush noresp", {31'd0, sawResp}, 32'd0);
    applyStimulus("mul 3x3", 3'd0, 32'd3, 32'd3, 1'b0);

    // Flush coinciding with a request cancels it.
    @(negedge clk);
    req_valid = 1'b1;
    flush     = 1'b1;
    req_op    = 3'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    checkOutput("flush+req ready", {31'd0, req_ready}, 32'd1);
    checkOutput("flush+req busy", {31'd0, alu_busy}, 32'd0);

    // Reset in the middle of an operation.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_a     = 32'd9;
    req_b     = 32'd9;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("midreset ready", {31'd0, req_ready}, 32'd1);
    checkOutput("midreset res", resp_res, 32'd0);

    // Randomized operations biased towards corner operands.
    for (int n = 0; n < 40; n++) begin
      rc = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       ra = 32'd0;
        1:       ra = 32'hFFFFFFFF;
        2:       ra = 32'h80000000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'h80000000;
        3:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      applyStimulus("random", rc, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
